// File: rtl/if_prefetch_pkg.sv
// Shared instruction-fetch definitions: NOP encoding, default queue depth,
// prefetch FSM states and the queue entry layout.
package if_prefetch_pkg;

    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam int unsigned IF_DEPTH_DEF = 4;

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } if_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of 64-bit fetch entries with a flush that empties it
// in one cycle and takes priority over push and pop.
module if_fifo
    import if_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH_DEF,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [63:0]   wdata_i,
    input  logic          pop_i,
    output logic [63:0]   rdata_o,
    output logic [CW-1:0] count_o
);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_i && !empty && !flush_i;
    assign push_ok = push_i && !flush_i && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: walks a combinational ROM into a small queue,
// hands words to the core over valid/ready and restarts on redirects.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH      = IF_DEPTH_DEF,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        inst_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    if_state_e   state_q;
    logic [CW-1:0] count;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    if_entry_t   wentry;
    if_entry_t   head;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty && inst_ready_i;
    assign push  = !jump_en_i && (!full || pop);

    assign wentry.addr = pc_q;
    assign wentry.inst = rom_data_i;

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (jump_en_i),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        pc_d = pc_q;
        if (jump_en_i) begin
            pc_d = {jump_addr_i[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_ADDR;
            state_q <= ST_RUN;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                ST_RUN:      state_q <= jump_en_i ? ST_REDIRECT : ST_RUN;
                ST_REDIRECT: state_q <= jump_en_i ? ST_REDIRECT : ST_RUN;
                default:     state_q <= ST_RUN;
            endcase
        end
    end

    assign rom_addr_o   = pc_q;
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? INST_NOP : head.inst;
    assign inst_addr_o  = empty ? pc_q : head.addr;

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: directed reset, backpressure,
// redirect and wrap-around scenarios.
module tb_if_prefetch;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        ready;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;

    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_data;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_addr;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign rom_data   = rom_word(rom_addr);
    assign w_rom_data = rom_word(w_rom_addr);

    if_prefetch #(
        .DEPTH      (4),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .inst_ready_i (ready),
        .inst_valid_o (valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr)
    );

    if_prefetch #(
        .DEPTH      (4),
        .RESET_ADDR (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .rom_addr_o   (w_rom_addr),
        .rom_data_i   (w_rom_data),
        .jump_en_i    (1'b0),
        .jump_addr_i  (32'h0),
        .inst_ready_i (1'b1),
        .inst_valid_o (w_valid),
        .inst_o       (w_inst),
        .inst_addr_o  (w_inst_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_fill(input logic [31:0] start, input int n);
        logic [31:0] a;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            sb.push_back({a, rom_word(a)});
        end
    endtask

    // Monitor: every handshake must match the next expected entry.
    always @(negedge clk) begin
        if (rst && valid && ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {inst_addr, inst}, 64'hX);
            end else begin
                check("pop_entry", {inst_addr, inst}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        ready     = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        step();
        step();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_inst", 64'(inst), 64'h13);
        check("rst_inst_addr", 64'(inst_addr), 64'h0);
        check("rst_rom_addr", 64'(rom_addr), 64'h0);
        check("rst_wrap_addr", 64'(w_rom_addr), 64'hFFFF_FFF8);

        // Reset release, free-running consumer
        sb_fill(32'h0, 16);
        rst   = 1'b1;
        ready = 1'b1;
        step();
        check("lat_valid", 64'(valid), 64'd1);
        check("lat_inst", 64'(inst), 64'(rom_word(32'h0)));
        check("lat_addr", 64'(inst_addr), 64'h0);
        check("wrap_valid", 64'(w_valid), 64'd1);
        check("wrap_a0", 64'(w_inst_addr), 64'hFFFF_FFF8);
        check("wrap_d0", 64'(w_inst), 64'(rom_word(32'hFFFF_FFF8)));
        step();
        check("stream_addr1", 64'(inst_addr), 64'h4);
        check("wrap_a1", 64'(w_inst_addr), 64'hFFFF_FFFC);
        step();
        check("wrap_a2", 64'(w_inst_addr), 64'h0);
        check("wrap_d2", 64'(w_inst), 64'(rom_word(32'h0)));
        step();
        step();
        ready = 1'b0;

        // Backpressure: fill to DEPTH and hold
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb_fill(32'h0, 16);
        for (int i = 0; i < 10; i++) step();
        check("bp_rom_addr", 64'(rom_addr), 64'h10);
        check("bp_valid", 64'(valid), 64'd1);
        check("bp_inst", 64'(inst), 64'(rom_word(32'h0)));
        check("bp_inst_addr", 64'(inst_addr), 64'h0);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ready = 1'b0;
        step();
        check("bp_refill_addr", 64'(rom_addr), 64'h24);
        check("bp_head", 64'(inst_addr), 64'h14);

        // Redirect while full
        jump_en   = 1'b1;
        jump_addr = 32'h40;
        step();
        jump_en = 1'b0;
        sb_fill(32'h40, 16);
        check("jmp_valid", 64'(valid), 64'd0);
        check("jmp_rom_addr", 64'(rom_addr), 64'h40);
        check("jmp_inst", 64'(inst), 64'h13);
        check("jmp_inst_addr", 64'(inst_addr), 64'h40);
        step();
        check("jmp_valid1", 64'(valid), 64'd1);
        check("jmp_head1", 64'(inst_addr), 64'h40);
        check("jmp_rom1", 64'(rom_addr), 64'h44);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Misaligned redirect with a same-cycle handshake
        jump_en   = 1'b1;
        jump_addr = 32'h43;
        step();
        jump_en = 1'b0;
        sb_fill(32'h40, 16);
        check("mis_rom_addr", 64'(rom_addr), 64'h40);
        check("mis_valid", 64'(valid), 64'd0);
        for (int i = 0; i < 3; i++) step();
        ready = 1'b0;

        // Asynchronous reset with three entries queued
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb_fill(32'h0, 16);
        for (int i = 0; i < 3; i++) step();
        check("pre_rst_valid", 64'(valid), 64'd1);
        check("pre_rst_rom", 64'(rom_addr), 64'hC);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_rom_addr", 64'(rom_addr), 64'h0);
        check("arst_inst", 64'(inst), 64'h13);
        check("arst_inst_addr", 64'(inst_addr), 64'h0);
        step();
        rst = 1'b1;
        sb_fill(32'h0, 16);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
